// File: rtl/mul_int16_seq.sv
// -----------------------------------------------------------------------------
// mul_int16_seq
//
// Sequential shift-and-add multiplier returning the lower WIDTH bits of A*B.
// One operand pair is accepted through a valid/ready handshake. A single
// WIDTH-bit adder is then reused for exactly WIDTH iterations, consuming one
// multiplier bit per cycle. The result is held under a valid/ready output
// handshake. The result is (A * B) mod 2^WIDTH, so it is identical for
// unsigned and two's-complement operands.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both sampled high. Ready/valid are decoded from the FSM
// state only, so neither depends combinationally on the partner's signal.
// Valid is never withdrawn before its transfer, and the data stays stable
// while valid is high.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand pair on A/B is valid
//   in_ready   out  1      block can accept an operand pair (IDLE)
//   A          in   WIDTH  multiplicand
//   B          in   WIDTH  multiplier
//   out_valid  out  1      P holds a completed product (DONE)
//   out_ready  in   1      consumer accepts P
//   P          out  WIDTH  registered lower WIDTH bits of A*B
//   busy       out  1      high in RUN and DONE
//   dbg_state  out  2      current FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
module mul_int16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_p;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_last;

    // Single shared adder; the carry out of the top bit is simply dropped,
    // which is what makes the product wrap modulo 2^WIDTH.
    assign w_addend = r_b[0] ? r_a : '0;
    assign w_sum    = r_acc + w_addend;

    // The step taken while cnt == WIDTH-1 is the WIDTH-th and final one.
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                // No early exit: the iteration count is always WIDTH.
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode (state only, no path from in_valid/out_ready)
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_RUN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Operands are captured only on the accepting edge.
                    if (in_valid) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum;
                    r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    // P changes only on the RUN->DONE edge and then holds
                    // through DONE and IDLE until the next completion.
                    if (w_last) begin
                        r_p <= w_sum;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign P         = r_p;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_int16_seq.sv
module tb_mul_int16_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks;
    int failures;

    logic [15:0] exp_q[$];

    mul_int16_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------ reference model
    // Product computed with plain wide arithmetic, reduced modulo 2^16.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint prod;
        prod = longint'(a) * longint'(b);
        return 16'(prod % 65536);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------- driver tasks
    task automatic accept_op(input logic [15:0] a, input logic [15:0] b);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        tick();
        exp_q.push_back(ref_mul(a, b));
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    // Waits for out_valid (bounded), checks latency, flags and the product.
    // With noise set, in_valid/A/B are toggled randomly while running.
    task automatic wait_done(input bit noise, output logic [15:0] got);
        int          lat;
        bit          bad;
        logic [15:0] exp_val;
        lat = 0;
        bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                A        = 16'($urandom);
                B        = 16'($urandom);
            end
            tick();
            lat++;
            if (!out_valid && (in_ready || !busy)) bad = 1'b1;
        end
        in_valid = 1'b0;
        check("latency_edges", 32'(lat), 32'd16);
        check("run_flags", {31'd0, bad}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        exp_val = 16'hxxxx;
        if (exp_q.size() > 0) exp_val = exp_q.pop_front();
        check("product", {16'd0, P}, {16'd0, exp_val});
        got = exp_val;
    endtask

    task automatic handshake(input logic [15:0] last);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_busy", {31'd0, busy}, 32'd0);
        check("post_hs_P_hold", {16'd0, P}, {16'd0, last});
    endtask

    // ------------------------------------------------------------ stimulus
    logic [15:0] dir_a[5] = '{16'd3, 16'hFFFF, 16'd300, 16'h1234, 16'h1234};
    logic [15:0] dir_b[5] = '{16'd5, 16'hFFFF, 16'd200, 16'h0010, 16'h0000};

    initial begin
        logic [15:0] got;
        int          n_acc;
        int          n_comp;
        int          cyc;
        int          last_c;
        bit          accepting;
        bit          seen;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_P", {16'd0, P}, 32'd0);

        // Directed operands (basic, wrap, shift, zero multiplier)
        for (int i = 0; i < 5; i++) begin
            accept_op(dir_a[i], dir_b[i]);
            wait_done(1'b0, got);
            handshake(got);
        end

        // Random operands with input noise during RUN
        for (int i = 0; i < 6; i++) begin
            accept_op(16'($urandom), 16'($urandom));
            wait_done(1'b1, got);
            handshake(got);
        end

        // Backpressure with in_valid noise while in DONE
        accept_op(16'($urandom), 16'($urandom));
        wait_done(1'b1, got);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            A        = 16'($urandom);
            B        = 16'($urandom);
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_P", {16'd0, P}, {16'd0, got});
        end
        in_valid = 1'b0;
        handshake(got);

        // Back-to-back: in_valid and out_ready held high, 4 random pairs
        in_valid  = 1'b1;
        out_ready = 1'b1;
        A         = 16'($urandom);
        B         = 16'($urandom);
        n_acc     = 0;
        n_comp    = 0;
        cyc       = 0;
        last_c    = -1;
        while (cyc < 200 && (n_acc < 4 || exp_q.size() > 0)) begin
            if (out_valid) begin
                got = 16'hxxxx;
                if (exp_q.size() > 0) got = exp_q.pop_front();
                check("b2b_product", {16'd0, P}, {16'd0, got});
                if (last_c >= 0) check("b2b_gap", 32'(cyc - last_c), 32'd18);
                last_c = cyc;
                n_comp++;
            end
            accepting = in_ready && in_valid;
            if (accepting) begin
                exp_q.push_back(ref_mul(A, B));
                n_acc++;
            end
            tick();
            cyc++;
            if (accepting) begin
                if (n_acc == 4) in_valid = 1'b0;
                A = 16'($urandom);
                B = 16'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_completions", 32'(n_comp), 32'd4);

        // Reset in the middle of RUN
        accept_op(16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(1, 16'hFFFF)));
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrun_rst_P", {16'd0, P}, 32'd0);
        check("midrun_rst_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("midrun_no_stale", {31'd0, seen}, 32'd0);
        accept_op(16'd7, 16'd9);
        wait_done(1'b0, got);
        check("after_rst_7x9", {16'd0, P}, 32'd63);
        handshake(got);

        // Reset in DONE together with out_ready
        accept_op(16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(3, 16'hFFFF)) | 16'd1);
        wait_done(1'b0, got);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        check("done_rst_P", {16'd0, P}, 32'd0);
        check("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("done_rst_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("done_rst_no_completion", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_int16_seq.md
# mul_int16_seq

Sequential controller for 16-bit integer multiplication that produces the lower WIDTH bits of the product. It latches one operand pair through a valid/ready handshake and reuses a single WIDTH-bit adder for WIDTH iterations, one multiplier bit per cycle. It then holds the result under a valid/ready output handshake. It is the area-minimal alternative to the fully unrolled adder-chain multiplier and shares its arithmetic contract: P = (A * B) mod 2^WIDTH, unsigned/two's-complement agnostic.

## Interface
- WIDTH, 16, operand and product width; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on A/B is valid.
- in_ready  output  1  block can accept an operand pair.
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- out_valid  output  1  P holds a completed product.
- out_ready  input  1  consumer accepts P.
- P  output  WIDTH  lower WIDTH bits of A*B, registered.
- busy  output  1  high in RUN and DONE states.

## Operation
- Internal registers: a_reg (WIDTH), b_reg (WIDTH), acc (WIDTH), cnt ($clog2(WIDTH) bits), state.
- Adder: single WIDTH-bit add, carry-out discarded. Each step computes acc + (b_reg[0] ? a_reg : 0).
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: a_reg←A, b_reg←B, acc←0, cnt←0, go to RUN.
  - RUN:
    - Per cycle: acc←acc + (b_reg[0] ? a_reg : 0); a_reg←a_reg<<1 (zero fill, truncated to WIDTH); b_reg←b_reg>>1; cnt←cnt+1.
    - When cnt==WIDTH-1, perform the final step, copy the sum to P, and go to DONE.
  - DONE:
    - out_valid=1; P stable.
    - On out_ready, go to IDLE.
- No early exit on zero multiplier bits. Iteration count is always exactly WIDTH.
- in_valid outside IDLE is ignored and creates no queued request. in_ready is low in RUN and DONE.
- A/B are sampled only on the accepting edge. Later changes on A/B do not affect the result.
- P is written only on the RUN→DONE transition. It keeps its value through IDLE until the next completion.
- Reset (any state, including mid-RUN or in DONE):
  - Next edge: state=IDLE, acc=0, P=0, cnt=0, a_reg=0, b_reg=0.
  - Any in-flight operation is discarded with no out_valid pulse.
  - rst has priority over in_valid and out_ready in the same cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, P=0.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid/out_ready to any output.
- Accept edge t, defined as the edge where in_valid & in_ready are sampled high:
  - RUN occupies edges t+1 … t+WIDTH.
  - out_valid rises after edge t+WIDTH and is observable in cycle t+WIDTH+1.
  - For WIDTH=16, latency from accept to out_valid is 17 cycles.
- Output handshake completes at the first edge where out_valid & out_ready are sampled high. in_ready is 1 in the following cycle.
- Back-to-back throughput: one result per WIDTH+2 cycles when out_ready is held high.
- Backpressure: out_valid and P stay constant for any number of cycles while out_ready=0.

## Test plan
- Basic: after reset, A=3, B=5 accepted at t → out_valid first high at t+17 with P=15. busy high from t+1 until the handshake, in_ready low throughout.
- Wrap: A=0xFFFF, B=0xFFFF → P=0x0001. A=300, B=200 → P=0xEA60. A=0x1234, B=0x0010 → P=0x2340. A=0x1234, B=0 → P=0x0000, still 17-cycle latency.
- Backpressure/ignore: hold out_ready=0 for 10 cycles after completion → P and out_valid unchanged. Toggle in_valid with new A/B during RUN and DONE → ignored, result unaffected.
- Back-to-back: in_valid and out_ready held high with 4 random pairs → each result matches (A*B)&0xFFFF; completions 18 cycles apart.
- Reset mid-operation: assert rst at cycle 8 of RUN → next cycle in_ready=1, out_valid=0, P=0, no stale result emerges. A new op with A=7, B=9 then yields P=63.
- Reset in DONE with out_ready=1 on the same cycle → reset wins, P=0, no completion counted.
